ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave_pkg.sv | 39 +++
 rtl/ahb_sram_core.sv | 27 ++
 rtl/ahb_sram_slave.sv | 104 ++++++++++
 tb/tb_ahb_sram_slave.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types, response codes, slave FSM states and byte-lane decode
// for the SRAM-backed AHB responder.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } ahb_slv_state_e;

  // Byte strobe for a little-endian 32-bit word; illegal sizes strobe nothing.
  function automatic logic [3:0] byte_lane_mask(input logic [2:0] hsize, input logic [1:0] offset);
    case (hsize)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// Word-organised RAM: byte-strobed synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_sram_core #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       strb,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite memory slave: decodes and latches the address phase, inserts
// WAIT_STATES per OKAY data phase and answers illegal transfers with ERROR.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  ahb_slv_state_e   state, next_state;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       off_q;
  logic [2:0]       size_q;
  logic             write_q;
  logic [3:0]       wait_cnt;

  logic        accept, illegal, misaligned, out_of_range;
  logic        mem_we;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata;

  // A new address phase can only land while this slave is driving hreadyout high.
  assign accept = hsel & hready & htrans[1] & (state inside {IDLE, DATA, ERR2});

  assign out_of_range = |haddr[ADDR_WIDTH-1:IDX_W+2];
  assign misaligned   = ((hsize == SIZE_HALF) && haddr[0]) ||
                        ((hsize == SIZE_WORD) && (haddr[1:0] != 2'b00));
  assign illegal      = (hsize > SIZE_WORD) || misaligned || out_of_range;

  always_comb begin
    next_state = IDLE;
    case (state)
      WAIT:    next_state = (wait_cnt == WS_LAST) ? DATA : WAIT;
      ERR1:    next_state = ERR2;
      default: begin
        if (accept) begin
          if (illegal)               next_state = ERR1;
          else if (WAIT_STATES == 0) next_state = DATA;
          else                       next_state = WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      wait_cnt  <= 4'd0;
      idx_q     <= '0;
      off_q     <= 2'b00;
      size_q    <= 3'd0;
      write_q   <= 1'b0;
    end else begin
      state     <= next_state;
      hreadyout <= !(next_state inside {WAIT, ERR1});
      hresp     <= (next_state inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;
      wait_cnt  <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (accept) begin
        idx_q   <= haddr[IDX_W+1:2];
        off_q   <= haddr[1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  assign mem_we   = (state == DATA) && write_q;
  assign mem_strb = byte_lane_mask(size_q, off_q);

  ahb_sram_core #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_core (
    .clk   (hclk),
    .we    (mem_we),
    .strb  (mem_strb),
    .idx   (idx_q),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  assign hrdata = ((state == DATA) && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed AHB master against two slaves (0 and 3 wait states) with a
// scoreboard of expected data-phase responses.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        use3;

  logic        ro0, ro3, resp0, resp3;
  logic [31:0] rd0, rd3;
  logic        hready_bus, hresp_bus;
  logic [31:0] hrdata_bus;

  assign hready_bus = use3 ? ro3 : ro0;
  assign hresp_bus  = use3 ? resp3 : resp0;
  assign hrdata_bus = use3 ? rd3 : rd0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & ~use3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
    .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel & use3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
    .hreadyout(ro3), .hresp(resp3), .hrdata(rd3)
  );

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [3:0]  waits;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  logic [31:0] pend_wd;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master beat: hold this address phase (and the previous beat's write
  // data) until the slave is ready, checking the previous data phase meanwhile.
  task automatic beat(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic        have;
    logic        legal;
    logic [31:0] w;
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = addr; hwdata = pend_wd;
    have = (sb.size() != 0);
    e    = have ? sb[0] : '0;
    n    = 0;
    while (!hready_bus && n < 40) begin
      chk("wait_hresp", {31'd0, hresp_bus}, {31'd0, e.err});
      n++;
      @(posedge hclk); #1;
    end
    if (n == 40) chk("ready_timeout", 32'd0, 32'd1);
    if (have) void'(sb.pop_front());
    chk("waits", n, {28'd0, e.waits});
    chk("hresp", {31'd0, hresp_bus}, {31'd0, e.err});
    chk("hrdata", hrdata_bus, e.rd ? e.data : 32'd0);
    @(posedge hclk); #1;
    pend_wd = wd;
    e = '0;
    if (sel && tr[1]) begin
      legal = !((sz > 3'd2) || (sz == 3'd1 && addr[0]) ||
                (sz == 3'd2 && addr[1:0] != 2'b00) || (addr[31:10] != 22'd0));
      if (!legal) begin
        e.err   = 1'b1;
        e.waits = 4'd1;
      end else begin
        e.waits = use3 ? 4'd3 : 4'd0;
        w = model[use3][addr[9:2]];
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (sz == 3'd2 || b == int'(addr[1:0]) || (sz == 3'd1 && b == int'(addr[1:0]) + 1))
              w[8*b +: 8] = wd[8*b +: 8];
          end
          model[use3][addr[9:2]] = w;
        end else begin
          e.rd   = 1'b1;
          e.data = w;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic drain();
    beat(1'b1, 2'd0, 1'b0, 3'd2, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    use3 = 1'b0; hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0; pend_wd = '0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_ready0", {31'd0, ro0}, 32'd1);
    chk("rst_resp0", {31'd0, resp0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_ready3", {31'd0, ro3}, 32'd1);
    chk("rst_resp3", {31'd0, resp3}, 32'd0);
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Zero-wait slave: word write then pipelined read.
    beat(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    beat(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    drain();
    // Byte merge into an existing word.
    beat(1, 2'd2, 1, 3'd2, 32'h10, 32'h11223344);
    beat(1, 2'd2, 1, 3'd0, 32'h13, 32'hAA000000);
    beat(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    // Halfword, top-of-memory word, out-of-range word.
    beat(1, 2'd2, 1, 3'd1, 32'h12, 32'h55660000);
    beat(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    beat(1, 2'd2, 1, 3'd2, 32'h3FC, 32'hCAFEF00D);
    beat(1, 2'd2, 0, 3'd2, 32'h3FC, 32'h0);
    beat(1, 2'd2, 1, 3'd2, 32'h400, 32'h12345678);
    beat(1, 2'd2, 0, 3'd2, 32'h400, 32'h0);
    // Misaligned and oversized transfers must not touch memory.
    beat(1, 2'd2, 1, 3'd2, 32'h402, 32'hFFFFFFFF);
    drain();
    beat(1, 2'd2, 1, 3'd3, 32'h10, 32'hFFFFFFFF);
    beat(1, 2'd2, 1, 3'd1, 32'h11, 32'hFFFFFFFF);
    beat(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    // Unselected and BUSY beats get zero-wait OKAY.
    beat(0, 2'd2, 1, 3'd2, 32'h10, 32'h0BADF00D);
    beat(1, 2'd1, 0, 3'd2, 32'h10, 32'h0);
    beat(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
    drain();
    drain();

    // Three-wait-state slave: SEQ write burst with a BUSY, then reads.
    use3 = 1'b1;
    beat(1, 2'd2, 1, 3'd2, 32'h40, 32'hA0A0A0A0);
    beat(1, 2'd3, 1, 3'd2, 32'h44, 32'hB1B1B1B1);
    beat(1, 2'd1, 1, 3'd2, 32'h48, 32'h0);
    beat(1, 2'd3, 1, 3'd2, 32'h48, 32'hC2C2C2C2);
    beat(1, 2'd3, 1, 3'd2, 32'h4C, 32'hD3D3D3D3);
    for (int i = 0; i < 4; i++)
      beat(1, (i == 0) ? 2'd2 : 2'd3, 0, 3'd2, 32'h40 + 32'(4 * i), 32'h0);
    beat(1, 2'd2, 1, 3'd2, 32'h20, 32'h01020304);
    beat(1, 2'd2, 1, 3'd2, 32'h404, 32'h0);
    drain();
    drain();

    // Reset in the middle of a write's wait states drops the write.
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20; hwdata = '0;
    @(posedge hclk); #1;
    chk("wr_in_wait", {31'd0, ro3}, 32'd0);
    htrans = 2'd0; hwdata = 32'h99999999;
    @(posedge hclk); #1;
    hreset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ro3}, 32'd1);
    chk("midrst_resp", {31'd0, resp3}, 32'd0);
    chk("midrst_rdata", rd3, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    sb.delete();
    pend_wd = '0;
    beat(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
    beat(1, 2'd2, 1, 3'd2, 32'h24, 32'h77665544);
    beat(1, 2'd2, 0, 3'd2, 32'h24, 32'h0);
    drain();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
